nios_project_onchip_memory_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 8192 x 32 on-chip RAM between two Avalon-MM style masters, e.g. the Nios II data master and a DMA/peripheral engine. It serializes accesses onto the RAM's one port using round-robin with a bounded hold. It routes the RAM's one-cycle-latency read data back to the master that issued the read. It sits between the interconnect masters and the RAM wrapper's address/byteenable/chipselect/write/writedata/readdata/clken/reset_req pins.

---
 rtl/nios_project_mem_arb_pkg.sv | 12 +
 rtl/nios_project_rr_arb2.sv | 34 +++
 rtl/nios_project_onchip_memory_arbiter.sv | 116 +++++++++++
 tb/tb_nios_project_onchip_memory_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_project_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package nios_project_mem_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int HOLD_W = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;
endpackage

// File: rtl/nios_project_rr_arb2.sv
// Two-way round-robin grant with bounded hold. Purely combinational, zero latency.
// Backpressure: the loser of a tie is simply not granted; the caller stalls it.
module nios_project_rr_arb2
  import nios_project_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic              req0,
  input  logic              req1,
  input  owner_t            last_owner,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              gnt_vld,
  output owner_t            gnt_owner
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  // hold_cnt == 0 means the port went idle, so nobody currently owns it and a
  // tie goes to the master that was not served last.
  always_comb begin
    gnt_vld   = req0 | req1;
    gnt_owner = M0;
    if (req0 && req1) begin
      if (hold_cnt != '0 && hold_cnt < MAX_HOLD_C) begin
        gnt_owner = last_owner;
      end else begin
        gnt_owner = (last_owner == M0) ? M1 : M0;
      end
    end else if (req1) begin
      gnt_owner = M1;
    end
  end

endmodule

// File: rtl/nios_project_onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters; 1 access/cycle, read data 1 cycle after accept.
// Backpressure: the non-granted requester sees waitrequest and must hold its request; waitrequest is high in reset.
module nios_project_onchip_memory_arbiter
  import nios_project_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = nios_project_mem_arb_pkg::ADDR_W,
  parameter int DATA_W   = nios_project_mem_arb_pkg::DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              ram_reset_req,
  input  logic [DATA_W-1:0] ram_readdata
);

  owner_t            last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rd_pend;
  owner_t            rd_tag;

  logic   req0, req1;
  logic   gnt_vld;
  owner_t gnt_owner;
  logic   accept;
  logic   sel_write;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  nios_project_rr_arb2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .hold_cnt   (hold_cnt),
    .gnt_vld    (gnt_vld),
    .gnt_owner  (gnt_owner)
  );

  // Nothing is accepted while reset is high, so the RAM never sees a write then.
  assign accept = gnt_vld & ~reset;

  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    sel_write      = m0_write;
    if (gnt_owner == M1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      sel_write      = m1_write;
    end
  end

  assign ram_chipselect = accept;
  assign ram_write      = accept & sel_write;
  assign ram_clken      = 1'b1;
  assign ram_reset_req  = reset;

  assign m0_waitrequest = reset | (req0 & ~(accept & (gnt_owner == M0)));
  assign m1_waitrequest = reset | (req1 & ~(accept & (gnt_owner == M1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= M1;
      hold_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= M0;
    end else begin
      rd_pend <= accept & ~sel_write;
      if (accept) begin
        rd_tag     <= gnt_owner;
        last_owner <= gnt_owner;
        if (gnt_owner != last_owner) begin
          hold_cnt <= HOLD_W'(1);
        end else if (hold_cnt != '1) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Data fans out to both masters; only the valid strobe follows the tag.
  // A strobe still pending when reset rises is dropped.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend & ~reset & (rd_tag == M0);
  assign m1_readdatavalid = rd_pend & ~reset & (rd_tag == M1);

endmodule

// File: tb/tb_nios_project_onchip_memory_arbiter.sv
// Directed bench for the two-master RAM arbiter with a 1-cycle-latency RAM model.
module tb_nios_project_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken, ram_reset_req;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios_project_onchip_memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_reset_req    (ram_reset_req),
    .ram_readdata     (ram_readdata)
  );

  // Behavioural single-port RAM: registers address/data at the edge, q valid next cycle.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end
      ram_readdata <= mem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  int  nvalid;
  int  g, pg;

  initial begin
    reset = 1'b1;
    idle_all();
    next_cycle();
    // A write presented during reset must not reach the RAM.
    m0_write = 1; m0_address = 13'h0005; m0_writedata = 32'h5555_5555;
    settle();
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_we", ram_write, 0);
    chk("rst_m0_vld", m0_readdatavalid, 0);
    chk("rst_m1_vld", m1_readdatavalid, 0);
    chk("rst_req", ram_reset_req, 1);
    chk("clken", ram_clken, 1);
    next_cycle();

    // Write then read back the same address.
    reset = 1'b0;
    m0_write = 1; m0_address = 13'h0005; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
    settle();
    chk("wr5_wait", m0_waitrequest, 0);
    chk("wr5_cs", ram_chipselect, 1);
    chk("wr5_we", ram_write, 1);
    chk("wr5_addr", ram_address, 32'h5);
    chk("wr5_data", ram_writedata, 32'hDEAD_BEEF);
    chk("rst_req_off", ram_reset_req, 0);
    next_cycle();
    m0_write = 0; m0_read = 1;
    settle();
    chk("rd5_wait", m0_waitrequest, 0);
    chk("rd5_we", ram_write, 0);
    next_cycle();
    idle_all();
    settle();
    chk("rd5_vld", m0_readdatavalid, 1);
    chk("rd5_data", m0_readdata, 32'hDEAD_BEEF);
    chk("rd5_m1_vld", m1_readdatavalid, 0);
    chk("idle_cs", ram_chipselect, 0);
    next_cycle();
    settle();
    chk("rd5_vld_once", m0_readdatavalid, 0);

    // Byte-lane merge at the top address, read back by the other master.
    m0_write = 1; m0_address = 13'h1FFF; m0_byteenable = 4'hF; m0_writedata = 32'hFFFF_FFFF;
    next_cycle();
    m0_byteenable = 4'h1; m0_writedata = 32'h0000_00AA;
    settle();
    chk("be_be", ram_byteenable, 32'h1);
    next_cycle();
    idle_all();
    m1_read = 1; m1_address = 13'h1FFF;
    settle();
    chk("be_m1_wait", m1_waitrequest, 0);
    chk("be_addr", ram_address, 32'h1FFF);
    next_cycle();
    idle_all();
    settle();
    chk("be_m1_vld", m1_readdatavalid, 1);
    chk("be_m0_vld", m0_readdatavalid, 0);
    chk("be_data", m1_readdata, 32'hFFFF_FFAA);
    next_cycle();

    // Read and write together count as a write.
    m0_read = 1; m0_write = 1; m0_address = 13'h0030; m0_writedata = 32'h1234_5678;
    settle();
    chk("rw_we", ram_write, 1);
    next_cycle();
    idle_all();
    settle();
    chk("rw_no_vld", m0_readdatavalid, 0);
    m0_read = 1; m0_address = 13'h0030;
    next_cycle();
    idle_all();
    settle();
    chk("rw_rb_data", m0_readdata, 32'h1234_5678);
    chk("rw_rb_vld", m0_readdatavalid, 1);

    // Preload fairness addresses, one from each master.
    m0_write = 1; m0_address = 13'h0010; m0_writedata = 32'hA0A0_A0A0;
    next_cycle();
    idle_all();
    m1_write = 1; m1_address = 13'h0020; m1_writedata = 32'hB1B1_B1B1;
    next_cycle();
    idle_all();
    reset = 1'b1;
    next_cycle();

    // Both masters read continuously from the first cycle after reset.
    reset = 1'b0;
    m0_read = 1; m0_address = 13'h0010;
    m1_read = 1; m1_address = 13'h0020;
    for (int i = 0; i < 16; i++) begin
      settle();
      g = (i / 4) % 2;
      chk($sformatf("rr%0d_m0_wait", i), m0_waitrequest, (g == 1) ? 1 : 0);
      chk($sformatf("rr%0d_m1_wait", i), m1_waitrequest, (g == 0) ? 1 : 0);
      chk($sformatf("rr%0d_addr", i), ram_address, (g == 1) ? 32'h20 : 32'h10);
      if (i > 0) begin
        pg = ((i - 1) / 4) % 2;
        chk($sformatf("rr%0d_m0_vld", i), m0_readdatavalid, (pg == 0) ? 1 : 0);
        chk($sformatf("rr%0d_m1_vld", i), m1_readdatavalid, (pg == 1) ? 1 : 0);
        chk($sformatf("rr%0d_data", i), m0_readdata, (pg == 1) ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
      end
      next_cycle();
    end
    idle_all();
    settle();
    chk("rr_tail_m1_vld", m1_readdatavalid, 1);
    chk("rr_tail_m0_vld", m0_readdatavalid, 0);
    next_cycle();

    // m1 alone: ten reads never stall even past MAX_HOLD.
    nvalid = 0;
    m1_read = 1; m1_address = 13'h0020;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("solo%0d_wait", k), m1_waitrequest, 0);
      if (m1_readdatavalid) nvalid++;
      next_cycle();
    end
    m0_read = 1; m0_address = 13'h0010;
    settle();
    if (m1_readdatavalid) nvalid++;
    chk("solo_nvalid", nvalid, 10);
    chk("solo_then_m0_wait", m0_waitrequest, 0);
    chk("solo_then_m1_wait", m1_waitrequest, 1);
    next_cycle();
    idle_all();
    next_cycle();

    // Reset right after an accepted read kills the pending strobe.
    m1_read = 1; m1_address = 13'h0020;
    next_cycle();
    idle_all();
    reset = 1'b1;
    settle();
    chk("mid_rst_vld", m1_readdatavalid, 0);
    chk("mid_rst_wait", m1_waitrequest, 1);
    next_cycle();
    reset = 1'b0;
    settle();
    chk("post_rst_vld", m1_readdatavalid, 0);
    m0_read = 1; m0_address = 13'h0010;
    m1_read = 1; m1_address = 13'h0020;
    settle();
    chk("post_rst_m0_wait", m0_waitrequest, 0);
    chk("post_rst_m1_wait", m1_waitrequest, 1);
    next_cycle();
    idle_all();
    settle();
    chk("post_rst_m0_vld", m0_readdatavalid, 1);
    chk("post_rst_m0_data", m0_readdata, 32'hA0A0_A0A0);
    chk("post_rst_m1_vld", m1_readdatavalid, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
